// File: rtl/icache_fetch_pkg.sv
// Shared definitions for the instruction-fetch cache: default geometry and
// refill state encodings.
package icache_fetch_pkg;

    localparam int ICACHE_ADDR_W   = 32;
    localparam int ICACHE_INST_W   = 32;
    localparam int ICACHE_INDEX_W  = 8;
    localparam int ICACHE_OFFSET_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_DONE   = 2'd2
    } icache_state_e;

endpackage

// File: rtl/icache_fetch_refill_fsm.sv
// Refill sequencer: latches the missing line, issues one word request at a
// time, and hands write strobes for the accepted words to the cache arrays.
module icache_refill_fsm
    import icache_fetch_pkg::*;
#(
    parameter int ADDR_W   = ICACHE_ADDR_W,
    parameter int OFFSET_W = ICACHE_OFFSET_W,
    parameter int LINE_W   = ADDR_W - OFFSET_W - 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                miss,
    input  logic [LINE_W-1:0]   line_addr,
    input  logic                mem_flag,
    input  logic [ADDR_W-1:0]   mem_addr,
    output logic                idle,
    output logic                req,
    output logic [ADDR_W-1:0]   req_addr,
    output logic                wr_en,
    output logic                wr_last,
    output logic [OFFSET_W-1:0] wr_word,
    output logic [LINE_W-1:0]   miss_line
);

    icache_state_e       state;
    logic [OFFSET_W-1:0] cnt;
    logic [LINE_W-1:0]   miss_line_q;
    logic [ADDR_W-1:0]   cur_addr;
    logic                accept;

    // Line base plus word counter gives the word currently being requested.
    assign cur_addr  = {miss_line_q, cnt, 2'b00};
    assign accept    = (state == ST_REFILL) && !rst && !flush && mem_flag
                       && (mem_addr == cur_addr);

    assign idle      = (state == ST_IDLE);
    assign req       = (state == ST_REFILL) && !rst;
    assign req_addr  = req ? cur_addr : '0;
    assign wr_en     = accept;
    assign wr_word   = cnt;
    assign wr_last   = accept && (&cnt);
    assign miss_line = miss_line_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!flush && miss) begin
                        miss_line_q <= line_addr;
                        cnt         <= '0;
                        state       <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    // Flush abandons the partial line; it was never marked valid.
                    if (flush) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else if (accept) begin
                        cnt <= cnt + 1'b1;
                        if (&cnt) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/icache_fetch.sv
// Instruction fetch stage with a direct-mapped multi-word-line cache; hits
// deliver in the same cycle, misses stall while the refill FSM fills the line.
module icache_fetch
    import icache_fetch_pkg::*;
#(
    parameter int ADDR_W   = ICACHE_ADDR_W,
    parameter int INST_W   = ICACHE_INST_W,
    parameter int INDEX_W  = ICACHE_INDEX_W,
    parameter int OFFSET_W = ICACHE_OFFSET_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] _pc,
    output logic [INST_W-1:0] _instruction,
    output logic              stall_flag,
    output logic              _instruction_read_flag,
    output logic [ADDR_W-1:0] _instruction_read_address,
    input  logic              instruction_flag,
    input  logic [ADDR_W-1:0] instruction_read_address,
    input  logic [INST_W-1:0] instruction
);

    localparam int LINES  = 1 << INDEX_W;
    localparam int WORDS  = 1 << OFFSET_W;
    localparam int LINE_W = ADDR_W - OFFSET_W - 2;
    localparam int TAG_W  = LINE_W - INDEX_W;

    logic [TAG_W-1:0]  tag_ram  [LINES];
    logic [INST_W-1:0] data_ram [LINES*WORDS];
    logic [LINES-1:0]  valid;

    logic [LINE_W-1:0]   pc_line;
    logic [TAG_W-1:0]    pc_tag;
    logic [INDEX_W-1:0]  pc_idx;
    logic [OFFSET_W-1:0] pc_off;
    logic                unused_byte_bits;

    logic                idle, line_hit, hit;
    logic                wr_en, wr_last;
    logic [OFFSET_W-1:0] wr_word;
    logic [LINE_W-1:0]   miss_line;
    logic [INDEX_W-1:0]  miss_idx;
    logic [TAG_W-1:0]    miss_tag;

    assign pc_line          = pc[ADDR_W-1:OFFSET_W+2];
    assign pc_tag           = pc_line[LINE_W-1:INDEX_W];
    assign pc_idx           = pc_line[INDEX_W-1:0];
    assign pc_off           = pc[OFFSET_W+1:2];
    assign unused_byte_bits = ^pc[1:0];

    assign miss_idx = miss_line[INDEX_W-1:0];
    assign miss_tag = miss_line[LINE_W-1:INDEX_W];

    // A matching tag on an invalid line is not a hit; cold address 0 must miss.
    assign line_hit = valid[pc_idx] && (tag_ram[pc_idx] == pc_tag);
    assign hit      = idle && line_hit && !flush && !rst;

    assign _pc          = hit ? pc : '0;
    assign _instruction = hit ? data_ram[{pc_idx, pc_off}] : '0;
    assign stall_flag   = !rst && !hit;

    icache_refill_fsm #(
        .ADDR_W   (ADDR_W),
        .OFFSET_W (OFFSET_W),
        .LINE_W   (LINE_W)
    ) u_refill (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .miss      (!line_hit),
        .line_addr (pc_line),
        .mem_flag  (instruction_flag),
        .mem_addr  (instruction_read_address),
        .idle      (idle),
        .req       (_instruction_read_flag),
        .req_addr  (_instruction_read_address),
        .wr_en     (wr_en),
        .wr_last   (wr_last),
        .wr_word   (wr_word),
        .miss_line (miss_line)
    );

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_ram[{miss_idx, wr_word}] <= instruction;
        end
        if (wr_last) begin
            tag_ram[miss_idx] <= miss_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid <= '0;
        end else if (wr_last) begin
            valid[miss_idx] <= 1'b1;
        end
    end

endmodule
